// File: rtl/pc_fetch_ctrl_pkg.sv
// rtl/pc_fetch_ctrl_pkg.sv - shared state encodings and vector defaults for the PC fetch controller
//
// Purpose : common types for pc_fetch_ctrl and its sub-module.
// Contents: pc_state_e (BOOT=0, RUN=1, WAIT=2, TRAP=3, HALT=4),
//           default reset/trap vectors, word-alignment helper.
package pc_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_RUN  = 3'd1,
        ST_WAIT = 3'd2,
        ST_TRAP = 3'd3,
        ST_HALT = 3'd4
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0180;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_add_4.sv
// rtl/pc_fetch_ctrl_add_4.sv - PC incrementer (pc + 4, modulo 2^32)
//
// Purpose: produce the sequential next PC.
// Ports  : a_i   in  32  current PC
//          sum_o out 32  a_i + 4, wraps silently
module pc_fetch_ctrl_add_4 (
    input  logic [31:0] a_i,
    output logic [31:0] sum_o
);

    assign sum_o = a_i + 32'd4;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter register and next-PC sequencer
//
// Purpose: holds the PC, selects the next PC from PC+4 / branch / jump /
//          jump-register targets, handles stall, imem wait, misaligned
//          jump-register traps and halt.
// Ports  : clk, rst_n (async active-low)
//          stall, imem_ready, halt              control inputs
//          branch_taken/branch_offset           branch redirect
//          jump/jump_index                      J-type redirect
//          jr/jr_target                         jump-register redirect
//          pc, pc_plus4                         current PC and PC+4
//          pc_valid                             PC is a live fetch address
//          trap                                 misaligned-jr pulse
//          state                                FSM state (debug)
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        pc_valid,
    output logic        trap,
    output logic [2:0]  state
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        jr_misaligned;
    logic        adv;

    pc_fetch_ctrl_add_4 u_add_4 (
        .a_i   (pc_q),
        .sum_o (pc_plus4)
    );

    // The shift discards offset[31:30]; the add wraps, so negative offsets work.
    assign branch_target = pc_plus4 + (branch_offset << 2);
    assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
    assign jr_misaligned = jr && is_misaligned(jr_target);

    // PC only advances from RUN with the instruction present and no hold.
    assign adv = (state_q == ST_RUN) && !halt && imem_ready && !stall;

    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (!imem_ready) begin
                    state_d = ST_WAIT;
                end else if (!stall) begin
                    if (jr_misaligned) begin
                        state_d = ST_TRAP;
                        pc_d    = TRAP_VECTOR;
                    end else begin
                        pc_d    = next_pc;
                    end
                end
            end
            // Returning to RUN does not advance: the returned instruction is
            // consumed by RUN on the following cycle.
            ST_WAIT: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (imem_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_TRAP: state_d = ST_RUN;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
        if (!adv && state_q == ST_RUN) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        pc_valid = 1'b0;
        trap     = 1'b0;
        unique case (state_q)
            ST_RUN,
            ST_WAIT: pc_valid = 1'b1;
            ST_TRAP: trap     = 1'b1;
            default: begin
                pc_valid = 1'b0;
                trap     = 1'b0;
            end
        endcase
    end

    assign pc    = pc_q;
    assign state = state_q;

endmodule
